// File: rtl/pilot_gen.sv
// pilot_gen: OFDM scattered-pilot pattern generator.
// Walks subcarriers k = 0..2^NFFT_LOG2-1 and emits one registered word per
// accepted advance. Each word flags the subcarrier as pilot, null (guard/DC)
// or data. Pilots also carry a PRBS-derived BPSK sign.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                source enable (request next subcarrier)
//   ready_in          downstream accepts the current word
//   scatter_en        rotating pattern enable, sampled when k = 0 is produced
//   valid_pilot       output word valid
//   index_pilot       current k is a pilot
//   sign_pilot        PRBS bit for current k (1 = BPSK -1)
//   null_sc           guard or DC subcarrier
//   sc_index          current k
//   sof / eof         k = 0 / k = N-1
//   sym_cnt           symbol number of the current word
module pilot_gen #(
  parameter int          NFFT_LOG2  = 10,
  parameter int          GUARD_LO   = 96,
  parameter int          GUARD_HI   = 95,
  parameter bit          DC_NULL    = 1'b1,
  parameter int          SPACING    = 12,
  parameter int          SHIFT_STEP = 3,
  parameter int          NSHIFT     = 4,
  parameter int          SYM_W      = 8,
  parameter logic [10:0] LFSR_SEED  = 11'h7FF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 ready_in,
  input  logic                 scatter_en,
  output logic                 valid_pilot,
  output logic                 index_pilot,
  output logic                 sign_pilot,
  output logic                 null_sc,
  output logic [NFFT_LOG2-1:0] sc_index,
  output logic                 sof,
  output logic                 eof,
  output logic [SYM_W-1:0]     sym_cnt
);

  localparam int N  = 1 << NFFT_LOG2;
  localparam int PW = $clog2(SPACING);

  localparam logic [NFFT_LOG2-1:0] K_LO   = NFFT_LOG2'(GUARD_LO);
  localparam logic [NFFT_LOG2-1:0] K_HI   = NFFT_LOG2'(N - 1 - GUARD_HI);
  localparam logic [NFFT_LOG2-1:0] K_DC   = NFFT_LOG2'(N / 2);
  localparam logic [NFFT_LOG2-1:0] K_LAST = NFFT_LOG2'(N - 1);
  localparam logic [PW-1:0]        SH_STEP = PW'(SHIFT_STEP);
  localparam logic [PW-1:0]        SH_MAX  = PW'((NSHIFT - 1) * SHIFT_STEP);
  localparam logic [PW-1:0]        PH_LAST = PW'(SPACING - 1);

  // State describing the *next* subcarrier to be emitted.
  logic [NFFT_LOG2-1:0] k_nxt;
  logic [SYM_W-1:0]     sym_nxt;
  logic [PW-1:0]        rot;      // (sym mod NSHIFT)*SHIFT_STEP for sym_nxt
  logic [PW-1:0]        shift_q;  // shift latched at k = 0 for this symbol
  logic [PW-1:0]        phase_q;
  logic [10:0]          lfsr_q;

  logic                 adv, is_k0, active, is_null, is_pilot;
  logic [PW-1:0]        shift_now, phase_now;
  logic [10:0]          lfsr_now;

  always_comb begin
    adv       = en && (!valid_pilot || ready_in);
    is_k0     = (k_nxt == '0);
    // k = 0 picks up a fresh shift and reseeds the PRBS; otherwise the
    // registered per-symbol values carry through.
    shift_now = is_k0 ? (scatter_en ? rot : '0) : shift_q;
    lfsr_now  = is_k0 ? LFSR_SEED : lfsr_q;
    // Phase restarts at the band edge so the first pilot lands at
    // GUARD_LO + shift. Outside the band phase is don't-care.
    if (k_nxt == K_LO)
      phase_now = (shift_now == '0) ? '0 : PW'(SPACING - int'(shift_now));
    else
      phase_now = phase_q;
    active    = (k_nxt >= K_LO) && (k_nxt <= K_HI);
    is_null   = !active || (DC_NULL && (k_nxt == K_DC));
    // A pilot that falls on DC is dropped, not relocated.
    is_pilot  = active && (phase_now == '0) && !is_null;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_pilot <= 1'b0;
      index_pilot <= 1'b0;
      sign_pilot  <= 1'b0;
      null_sc     <= 1'b0;
      sc_index    <= '0;
      sof         <= 1'b0;
      eof         <= 1'b0;
      sym_cnt     <= '0;
      k_nxt       <= '0;
      sym_nxt     <= '0;
      rot         <= '0;
      shift_q     <= '0;
      phase_q     <= '0;
      lfsr_q      <= LFSR_SEED;
    end else if (adv) begin
      valid_pilot <= 1'b1;
      index_pilot <= is_pilot;
      sign_pilot  <= lfsr_now[10];
      null_sc     <= is_null;
      sc_index    <= k_nxt;
      sof         <= is_k0;
      eof         <= (k_nxt == K_LAST);
      sym_cnt     <= sym_nxt;
      k_nxt       <= k_nxt + NFFT_LOG2'(1);
      shift_q     <= shift_now;
      phase_q     <= (phase_now == PH_LAST) ? '0 : phase_now + PW'(1);
      // x^11 + x^9 + 1, stepped on every subcarrier.
      lfsr_q      <= {lfsr_now[9:0], lfsr_now[10] ^ lfsr_now[8]};
      if (k_nxt == K_LAST) begin
        sym_nxt <= sym_nxt + SYM_W'(1);
        rot     <= (rot == SH_MAX) ? '0 : rot + SH_STEP;
      end
    end else if (ready_in) begin
      // Word consumed with no new request: drop valid, state holds.
      valid_pilot <= 1'b0;
    end
  end

endmodule
